// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter slice.
// Requester ids double as the round-robin history bit.
package rf_pkg;

  localparam int NUM_REGS = 32;
  localparam int AW       = 5;
  localparam int DW       = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // The requester that should win a tie given who won last time.
  function automatic req_id_e other_req(input req_id_e last);
    return (last == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-write counters: issue admission and RAW busy lookup.
// A commit is a registered register-file write; it retires one outstanding write.
module rf_scoreboard #(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int AW       = rf_pkg::AW,
  parameter int CNT_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          commit,
  input  logic [AW-1:0] commit_rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          rs_busy,
  output logic          rt_busy
);
  import rf_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                commit_hits_issue;
  logic                issue_acc;
  logic                underflow;

  // A saturated register may still be allocated when a commit frees a slot in the same cycle.
  always_comb begin
    commit_hits_issue = commit && (commit_rd == issue_rd);
    issue_ready       = !rst && ((issue_rd == REG_ZERO) ||
                                 (cnt[issue_rd] != CNT_MAX) ||
                                 commit_hits_issue);
    issue_acc         = issue_valid && issue_ready && (issue_rd != REG_ZERO);
    inc_vec           = '0;
    dec_vec           = '0;
    if (issue_acc) begin
      inc_vec[issue_rd] = 1'b1;
    end
    if (commit && (commit_rd != REG_ZERO)) begin
      dec_vec[commit_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Busy stays high during the commit cycle; the file holds the value only afterwards.
  assign rs_busy = (rs != REG_ZERO) && (cnt[rs] != '0);
  assign rt_busy = (rt != REG_ZERO) && (cnt[rt] != '0);

  // Retiring a write that was never allocated means the issue stage lost track.
  assign underflow = commit && (commit_rd != REG_ZERO) && (cnt[commit_rd] == '0);

  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !underflow);

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and load unit (B), with a registered write stage and a RAW hazard scoreboard.
module rf_write_arbiter #(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int AW       = rf_pkg::AW,
  parameter int DW       = rf_pkg::DW,
  parameter int CNT_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_wdata,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          rs_busy,
  output logic          rt_busy
);
  import rf_pkg::*;

  req_id_e       last_grant;
  logic          grant_a;
  logic          grant_b;
  logic          xfer;
  logic          xfer_writes;
  logic [AW-1:0] win_rd;
  logic [DW-1:0] win_data;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && (!b_valid || (other_req(last_grant) == REQ_A))) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    xfer        = grant_a || grant_b;
    win_rd      = grant_a ? a_rd : b_rd;
    win_data    = grant_a ? a_data : b_data;
    xfer_writes = xfer && (win_rd != REG_ZERO);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Writes to register 0 complete the handshake but never reach the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      last_grant <= REQ_B;
    end else begin
      rf_we <= xfer_writes;
      if (xfer) begin
        last_grant <= grant_a ? REQ_A : REQ_B;
      end
      if (xfer_writes) begin
        rf_rd    <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .commit      (rf_we),
    .commit_rd   (rf_rd),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected register-file writes are queued
// at stimulus time and retired by a monitor whenever rf_we is seen.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        rs_busy;
  logic        rt_busy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rf_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic bv, input logic [4:0] brd, input logic [31:0] bdata,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] rsi, input logic [4:0] rti);
    @(negedge clk);
    a_valid     = av;
    a_rd        = ard;
    a_data      = adata;
    b_valid     = bv;
    b_rd        = brd;
    b_data      = bdata;
    issue_valid = iv;
    issue_rd    = ird;
    rs          = rsi;
    rt          = rti;
    #1;
  endtask

  // The write granted before the coming edge must appear in the following cycle.
  task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst && rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", rf_rd, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_rd !== e.rd || rf_wdata !== e.data || cyc != e.due) begin
          n_fail++;
          $display("[TB] FAIL write_cmp: got rd=%0d data=0x%0h cycle=%0d, expected rd=%0d data=0x%0h cycle=%0d",
                   rf_rd, rf_wdata, cyc, e.rd, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] arb_data [4];
    logic [4:0]  arb_rd   [4];
    arb_data = '{32'hA000_0003, 32'hB000_0004, 32'hA000_0003, 32'hB000_0004};
    arb_rd   = '{5'd3, 5'd4, 5'd3, 5'd4};

    // Reset: requester A already waiting, nothing may be granted.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    issue_valid = 1'b1; issue_rd = 5'd5; rs = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] reset checks");
    checkFlag("reset_a_ready", a_ready, 1'b0);
    checkFlag("reset_b_ready", b_ready, 1'b0);
    checkFlag("reset_rf_we", rf_we, 1'b0);
    checkOutput("reset_rf_rd", {27'b0, rf_rd}, 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    checkFlag("reset_rs_busy", rs_busy, 1'b0);

    // Release reset with A's write to r5 presented and r5 allocated in the same cycle.
    rst = 1'b0;
    #1;
    checkFlag("t1_a_ready", a_ready, 1'b1);
    checkFlag("t1_issue_ready", issue_ready, 1'b1);
    expectWrite(5'd5, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    checkFlag("t1_rf_we_n1", rf_we, 1'b1);
    checkFlag("t1_busy_during_commit", rs_busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    checkFlag("t1_rf_we_n2", rf_we, 1'b0);
    checkFlag("t1_busy_after_commit", rs_busy, 1'b0);

    // Register 0: handshake completes, no write, never busy.
    $display("[TB] register zero checks");
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h0000_1234, 1, 5'd0, 5'd0, 0);
    checkFlag("r0_b_ready", b_ready, 1'b1);
    checkFlag("r0_a_ready", a_ready, 1'b0);
    checkFlag("r0_issue_ready", issue_ready, 1'b1);
    checkFlag("r0_rs_busy", rs_busy, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkFlag("r0_rf_we", rf_we, 1'b0);
    checkOutput("r0_rf_rd_hold", {27'b0, rf_rd}, 32'd5);
    checkOutput("r0_rf_wdata_hold", rf_wdata, 32'hDEAD_BEEF);

    // Both requesters held valid for four cycles; last winner was B so A goes first.
    $display("[TB] round-robin checks");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 5'd3, 32'hA000_0003, 1, 5'd4, 32'hB000_0004, 1, arb_rd[k], 0, 0);
      checkFlag($sformatf("arb_a_ready_%0d", k), a_ready, (k % 2) == 0);
      checkFlag($sformatf("arb_b_ready_%0d", k), b_ready, (k % 2) == 1);
      checkFlag($sformatf("arb_issue_ready_%0d", k), issue_ready, 1'b1);
      expectWrite(arb_rd[k], arb_data[k]);
    end

    // Saturate r7 with three allocations; the fourth is refused.
    $display("[TB] saturation checks");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
      checkFlag($sformatf("sat_issue_ready_%0d", k), issue_ready, 1'b1);
    end
    applyStimulus(1, 5'd7, 32'h7000_0001, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    checkFlag("sat_issue_refused", issue_ready, 1'b0);
    checkFlag("sat_rs_busy", rs_busy, 1'b1);
    checkFlag("sat_a_ready", a_ready, 1'b1);
    expectWrite(5'd7, 32'h7000_0001);
    applyStimulus(1, 5'd7, 32'h7000_0002, 0, 0, 0, 0, 0, 5'd7, 0);
    expectWrite(5'd7, 32'h7000_0002);
    applyStimulus(1, 5'd7, 32'h7000_0003, 0, 0, 0, 0, 0, 5'd7, 0);
    expectWrite(5'd7, 32'h7000_0003);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checkFlag("sat_busy_last_commit", rs_busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checkFlag("sat_busy_cleared", rs_busy, 1'b0);

    // r9: allocation and commit in the same cycle leave one write outstanding.
    $display("[TB] same-cycle issue/commit checks");
    applyStimulus(1, 5'd9, 32'h9999_9999, 0, 0, 0, 1, 5'd9, 0, 5'd9);
    checkFlag("r9_issue_ready_1", issue_ready, 1'b1);
    expectWrite(5'd9, 32'h9999_9999);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9);
    checkFlag("r9_issue_ready_2", issue_ready, 1'b1);
    checkFlag("r9_rt_busy_commit", rt_busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    checkFlag("r9_rt_busy_after", rt_busy, 1'b1);
    checkFlag("r9_rs_busy_after", rs_busy, 1'b1);

    // Reset right after an accepted write to r12 (two outstanding): write dropped.
    $display("[TB] mid-operation reset checks");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 5'd9);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 5'd9);
    applyStimulus(1, 5'd12, 32'hC0C0_C0C0, 0, 0, 0, 0, 0, 5'd12, 5'd9);
    checkFlag("mr_a_ready", a_ready, 1'b1);
    checkFlag("mr_rs_busy_before", rs_busy, 1'b1);
    @(posedge clk);
    #1;
    checkFlag("mr_rf_we_inflight", rf_we, 1'b1);
    checkOutput("mr_rf_rd_inflight", {27'b0, rf_rd}, 32'd12);
    #1;
    rst = 1'b1;
    #1;
    checkFlag("mr_rf_we_dropped", rf_we, 1'b0);
    checkFlag("mr_rs_busy", rs_busy, 1'b0);
    checkFlag("mr_rt_busy", rt_busy, 1'b0);
    checkFlag("mr_a_ready_in_reset", a_ready, 1'b0);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 5'd12;
    #1;
    checkFlag("mr_issue_ready_after", issue_ready, 1'b1);
    checkFlag("mr_rs_busy_after", rs_busy, 1'b0);
    checkFlag("mr_rf_we_after", rf_we, 1'b0);

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pending_writes", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
